// File: rtl/alarm_zone_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : security_pkg
//  Brief    : Shared states, strobe bit mapping and timing defaults for the
//             alarm sequencer and the FSM it feeds.
//  Revision : 1.0
// ============================================================================
package security_pkg;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_watch   = 3'd1;
    localparam logic [2:0] c_st_entry   = 3'd2;
    localparam logic [2:0] c_st_latched = 3'd3;

    localparam int c_stb_arm     = 0;
    localparam int c_stb_trig    = 1;
    localparam int c_stb_confirm = 2;
    localparam int c_stb_w       = 3;

    localparam int c_def_nzones      = 4;
    localparam int c_def_debounce    = 4;
    localparam int c_def_entry_delay = 16;
    localparam int c_def_fb_timeout  = 4;

    // Returns {valid, index} of the first set request at or above ptr, wrapping at n.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                           input int n);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = 7; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[3'(idx)]) res = {1'b1, 3'(idx)};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_zone_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_zone_scheduler_if
//  Brief    : User requests, sensors, FSM strobes and status of the sequencer.
//  Revision : 1.0
// ============================================================================
interface alarm_zone_scheduler_if
    import security_pkg::*;
#(
    parameter int NZONES = c_def_nzones
);
    logic              arm_req;
    logic              disarm_req;
    logic [NZONES-1:0] zone_in;
    logic [NZONES-1:0] zone_mask;
    logic              alarm_fb;
    logic              arm_o;
    logic              trig_o;
    logic              confirm_o;
    logic              clear_o;
    logic [2:0]        active_zone;
    logic [2:0]        sched_state;
    logic              fault;

    modport master (
        output arm_req, disarm_req, zone_in, zone_mask, alarm_fb,
        input  arm_o, trig_o, confirm_o, clear_o, active_zone, sched_state, fault
    );

    modport slave (
        input  arm_req, disarm_req, zone_in, zone_mask, alarm_fb,
        output arm_o, trig_o, confirm_o, clear_o, active_zone, sched_state, fault
    );
endinterface
`default_nettype wire

// File: rtl/alarm_zone_scheduler_zone_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : zone_debounce
//  Brief    : Saturating run-length counter; flags a zone after DEBOUNCE highs.
//  Revision : 1.0
// ============================================================================
module zone_debounce
    import security_pkg::*;
#(
    parameter int DEBOUNCE = c_def_debounce
) (
    input  logic clk,
    input  logic rst,
    input  logic i_zone,
    output logic o_zone_db
);
    localparam int               c_cw  = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [c_cw-1:0]  c_max = c_cw'(DEBOUNCE);
    localparam logic [c_cw-1:0]  c_one = c_cw'(1);

    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt;
    logic            r_db;

    always_comb begin
        w_cnt = '0;
        if (i_zone) w_cnt = (r_cnt == c_max) ? r_cnt : r_cnt + c_one;
    end

    // The flag tracks the post-edge count so it rises on the DEBOUNCE-th high sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else begin
            r_cnt <= w_cnt;
            r_db  <= (w_cnt == c_max);
        end
    end

    assign o_zone_db = r_db;
endmodule
`default_nettype wire

// File: rtl/alarm_zone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_zone_scheduler
//  Brief    : Debounces zones, grants one round-robin, runs the entry delay and
//             strobes the alarm FSM; flags a missing alarm acknowledge.
//  Revision : 1.0
// ============================================================================
module alarm_zone_scheduler
    import security_pkg::*;
#(
    parameter int NZONES      = c_def_nzones,
    parameter int DEBOUNCE    = c_def_debounce,
    parameter int ENTRY_DELAY = c_def_entry_delay,
    parameter int FB_TIMEOUT  = c_def_fb_timeout
) (
    input  logic                 clk,
    input  logic                 rst,
    alarm_zone_scheduler_if.slave bus
);
    localparam int              c_ew       = $clog2(ENTRY_DELAY + 1);
    localparam int              c_fw       = $clog2(FB_TIMEOUT + 1);
    localparam logic [c_ew-1:0] c_ent_load = c_ew'(ENTRY_DELAY);
    localparam logic [c_ew-1:0] c_ent_one  = c_ew'(1);
    localparam logic [c_fw-1:0] c_fb_load  = c_fw'(FB_TIMEOUT);
    localparam logic [c_fw-1:0] c_fb_one   = c_fw'(1);
    localparam logic [2:0]      c_last     = 3'(NZONES - 1);

    logic [NZONES-1:0]  w_zone_db;
    logic [3:0]         w_pick;
    logic               w_grant_vld;
    logic [2:0]         w_grant_idx;

    logic [2:0]         r_state,  w_state;
    logic [c_stb_w-1:0] r_strobe, w_strobe;
    logic               r_clear,  w_clear;
    logic [2:0]         r_active, w_active;
    logic [2:0]         r_rr,     w_rr;
    logic [c_ew-1:0]    r_ent,    w_ent;
    logic [c_fw-1:0]    r_fb,     w_fb;
    logic               r_fault,  w_fault;
    logic               r_seen,   w_seen;

    for (genvar gi = 0; gi < NZONES; gi++) begin : g_zone
        zone_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_db (
            .clk       (clk),
            .rst       (rst),
            .i_zone    (bus.zone_in[gi]),
            .o_zone_db (w_zone_db[gi])
        );
    end

    // Masking is applied only here; debounce keeps running on masked zones.
    assign w_pick      = rr_pick(8'(w_zone_db & bus.zone_mask), r_rr, NZONES);
    assign w_grant_vld = w_pick[3];
    assign w_grant_idx = w_pick[2:0];

    always_comb begin
        w_state  = r_state;
        w_strobe = '0;
        w_clear  = 1'b0;
        w_active = r_active;
        w_rr     = r_rr;
        w_ent    = r_ent;
        w_fb     = r_fb;
        w_fault  = r_fault;
        w_seen   = r_seen;
        case (r_state)
            c_st_idle: begin
                if (!bus.disarm_req && bus.arm_req) begin
                    w_strobe[c_stb_arm] = 1'b1;
                    w_state             = c_st_watch;
                end
            end
            c_st_watch: begin
                if (bus.disarm_req) begin
                    w_clear = 1'b1;
                    w_state = c_st_idle;
                end else if (w_grant_vld) begin
                    w_strobe[c_stb_trig] = 1'b1;
                    w_active             = w_grant_idx;
                    w_rr                 = (w_grant_idx == c_last) ? 3'd0 : w_grant_idx + 3'd1;
                    w_ent                = c_ent_load;
                    w_state              = c_st_entry;
                end
            end
            c_st_entry: begin
                if (bus.disarm_req) begin
                    w_clear = 1'b1;
                    w_state = c_st_idle;
                end else if (r_ent == c_ent_one) begin
                    w_strobe[c_stb_confirm] = 1'b1;
                    w_fb                    = c_fb_load;
                    w_state                 = c_st_latched;
                end else begin
                    w_ent = r_ent - c_ent_one;
                end
            end
            c_st_latched: begin
                if (bus.alarm_fb) begin
                    w_seen = 1'b1;
                end else if (r_fb != '0) begin
                    w_fb = r_fb - c_fb_one;
                    if (r_fb == c_fb_one && !r_seen) w_fault = 1'b1;
                end
            end
            default: w_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_strobe <= '0;
            r_clear  <= 1'b0;
            r_active <= 3'd0;
            r_rr     <= 3'd0;
            r_ent    <= '0;
            r_fb     <= '0;
            r_fault  <= 1'b0;
            r_seen   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_strobe <= w_strobe;
            r_clear  <= w_clear;
            r_active <= w_active;
            r_rr     <= w_rr;
            r_ent    <= w_ent;
            r_fb     <= w_fb;
            r_fault  <= w_fault;
            r_seen   <= w_seen;
        end
    end

    assign bus.arm_o       = r_strobe[c_stb_arm];
    assign bus.trig_o      = r_strobe[c_stb_trig];
    assign bus.confirm_o   = r_strobe[c_stb_confirm];
    assign bus.clear_o     = r_clear;
    assign bus.active_zone = r_active;
    assign bus.sched_state = r_state;
    assign bus.fault       = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_alarm_zone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_zone_scheduler
//  Brief    : Directed and random stimulus against a time-stamp reference model.
//  Revision : 1.0
// ============================================================================
module tb_alarm_zone_scheduler;
    localparam int NZ  = 4;
    localparam int DEB = 4;
    localparam int ENT = 16;
    localparam int FBT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    alarm_zone_scheduler_if #(.NZONES(NZ)) bus ();

    alarm_zone_scheduler #(
        .NZONES      (NZ),
        .DEBOUNCE    (DEB),
        .ENTRY_DELAY (ENT),
        .FB_TIMEOUT  (FBT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: states 0..3, edge time stamps and per-zone run lengths.
    int m_state, m_rr, m_active, m_fault, m_seen, t_trig, t_conf, cyc;
    int e_arm, e_trig, e_conf, e_clr;
    int run [NZ];

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int g;
        cyc++;
        e_arm = 0; e_trig = 0; e_conf = 0; e_clr = 0;
        if (rst) begin
            m_state = 0; m_rr = 0; m_active = 0; m_fault = 0; m_seen = 0;
            for (int i = 0; i < NZ; i++) run[i] = 0;
            return;
        end
        case (m_state)
            0: if (!bus.disarm_req && bus.arm_req) begin e_arm = 1; m_state = 1; end
            1: begin
                if (bus.disarm_req) begin
                    e_clr = 1; m_state = 0;
                end else begin
                    g = -1;
                    for (int k = 0; k < NZ; k++)
                        if (g < 0 && run[(m_rr + k) % NZ] >= DEB && bus.zone_mask[(m_rr + k) % NZ])
                            g = (m_rr + k) % NZ;
                    if (g >= 0) begin
                        e_trig = 1; m_active = g; m_rr = (g + 1) % NZ;
                        t_trig = cyc; m_state = 2;
                    end
                end
            end
            2: begin
                if (bus.disarm_req) begin
                    e_clr = 1; m_state = 0;
                end else if (cyc - t_trig == ENT) begin
                    e_conf = 1; t_conf = cyc; m_state = 3;
                end
            end
            default: begin
                if (!m_seen) begin
                    if (bus.alarm_fb) m_seen = 1;
                    else if (cyc - t_conf == FBT) m_fault = 1;
                end
            end
        endcase
        for (int i = 0; i < NZ; i++) run[i] = bus.zone_in[i] ? (run[i] < 1000 ? run[i] + 1 : run[i]) : 0;
    endtask

    task automatic tick();
        int act, exp;
        @(posedge clk);
        model_edge();
        #1;
        act = (int'(bus.arm_o) << 10) | (int'(bus.trig_o) << 9) | (int'(bus.confirm_o) << 8) |
              (int'(bus.clear_o) << 7) | (int'(bus.active_zone) << 4) |
              (int'(bus.sched_state) << 1) | int'(bus.fault);
        exp = (e_arm << 10) | (e_trig << 9) | (e_conf << 8) | (e_clr << 7) |
              (m_active << 4) | (m_state << 1) | m_fault;
        chk_eq("outs", act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.arm_req = 1'b0; bus.disarm_req = 1'b0; bus.alarm_fb = 1'b0;
        bus.zone_in = '0;   bus.zone_mask = '1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic arm_pulse();
        bus.arm_req = 1'b1;
        tick();
        bus.arm_req = 1'b0;
    endtask

    // which: 0 = trig_o, 1 = confirm_o, 2 = fault; n counts ticks up to the hit.
    task automatic run_until(input int which, input int bound, output int n);
        logic hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < bound) begin
            tick();
            n++;
            case (which)
                0:       hit = bus.trig_o;
                1:       hit = bus.confirm_o;
                default: hit = bus.fault;
            endcase
        end
        chk_eq($sformatf("reach_%0d", which), int'(hit), 1);
    endtask

    initial begin
        int        n, trig_cnt;
        logic [NZ-1:0] z;
        m_state = 0; m_rr = 0; m_active = 0; m_fault = 0; m_seen = 0;
        t_trig = 0; t_conf = 0; cyc = 0;
        for (int i = 0; i < NZ; i++) run[i] = 0;

        // Reset, arm, single zone through confirm with a prompt alarm acknowledge
        do_reset();
        tick();
        chk_eq("rst_state", int'(bus.sched_state), 0);
        arm_pulse();
        chk_eq("arm_pulse", int'(bus.arm_o), 1);
        chk_eq("arm_state", int'(bus.sched_state), 1);
        bus.zone_in = 4'b0100;
        run_until(0, 20, n);
        chk_eq("trig_lat", n, DEB + 1);
        chk_eq("zone2", int'(bus.active_zone), 2);
        run_until(1, 40, n);
        chk_eq("conf_lat", n, ENT);
        tick();
        bus.alarm_fb = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk_eq("no_fault", int'(bus.fault), 0);

        // Glitch shorter than the debounce window
        do_reset();
        arm_pulse();
        trig_cnt = 0;
        bus.zone_in = 4'b0001;
        for (int i = 0; i < 3; i++) begin tick(); trig_cnt += int'(bus.trig_o); end
        bus.zone_in = '0;
        for (int i = 0; i < 10; i++) begin tick(); trig_cnt += int'(bus.trig_o); end
        chk_eq("glitch_trig", trig_cnt, 0);
        chk_eq("glitch_state", int'(bus.sched_state), 1);

        // Round robin with mask, then disarm at the final entry cycle
        do_reset();
        bus.zone_in = 4'b1111; bus.zone_mask = 4'b1010;
        arm_pulse();
        run_until(0, 20, n);
        chk_eq("rr_first", int'(bus.active_zone), 1);
        bus.disarm_req = 1'b1;
        tick();
        chk_eq("rr_clear", int'(bus.clear_o), 1);
        bus.disarm_req = 1'b0;
        arm_pulse();
        run_until(0, 5, n);
        chk_eq("rr_second", int'(bus.active_zone), 3);
        for (int i = 0; i < ENT - 1; i++) tick();
        bus.disarm_req = 1'b1;
        tick();
        chk_eq("late_clear", int'(bus.clear_o), 1);
        chk_eq("late_noconf", int'(bus.confirm_o), 0);
        chk_eq("late_state", int'(bus.sched_state), 0);
        bus.arm_req = 1'b1;
        tick();
        chk_eq("both_noarm", int'(bus.arm_o), 0);
        chk_eq("both_state", int'(bus.sched_state), 0);
        bus.arm_req = 1'b0; bus.disarm_req = 1'b0;

        // Missing acknowledge raises a sticky fault
        do_reset();
        bus.zone_in = 4'b0001;
        arm_pulse();
        run_until(0, 20, n);
        run_until(1, 40, n);
        run_until(2, 10, n);
        chk_eq("fault_lat", n, FBT);
        bus.disarm_req = 1'b1; bus.arm_req = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk_eq("fault_sticky", int'(bus.fault), 1);
        chk_eq("latched_state", int'(bus.sched_state), 3);
        do_reset();
        chk_eq("fault_cleared", int'(bus.fault), 0);

        // Reset in the middle of the entry delay
        bus.zone_in = 4'b0010;
        arm_pulse();
        run_until(0, 20, n);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("mid_rst_state", int'(bus.sched_state), 0);
        chk_eq("mid_rst_noconf", int'(bus.confirm_o), 0);
        chk_eq("mid_rst_noclr", int'(bus.clear_o), 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            z = bus.zone_in;
            for (int i = 0; i < NZ; i++) if ($urandom_range(0, 7) == 0) z[i] = ~z[i];
            bus.zone_in = z;
            if ($urandom_range(0, 49) == 0) bus.zone_mask = 4'($urandom);
            bus.arm_req    = ($urandom_range(0, 3) == 0);
            bus.disarm_req = ($urandom_range(0, 39) == 0);
            bus.alarm_fb   = ($urandom_range(0, 2) == 0);
            rst            = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
